// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared widths, reset vector and next-PC select encoding
package pc_seq_pkg;
    localparam int PC_W = 16;
    localparam logic [PC_W-1:0] RESET_VEC = 16'h0000;
    typedef enum logic [2:0] {SEL_HOLD, SEL_INC, SEL_JUMP, SEL_CALL, SEL_RET, SEL_CLR} sel_t;
endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: decode-side requests and PC/stack status of the sequencer
interface pc_sequencer_if #(parameter int DEPTH = 8);
    import pc_seq_pkg::*;
    localparam int SPW = $clog2(DEPTH) + 1;
    logic            soft_clr;
    logic            stall;
    logic            jump_en;
    logic            call_en;
    logic            ret_en;
    logic [PC_W-1:0] jump_addr;
    logic [PC_W-1:0] pc;
    logic [SPW-1:0]  sp;
    logic            ovf;
    logic            udf;
    modport master (output soft_clr, stall, jump_en, call_en, ret_en, jump_addr,
                    input pc, sp, ovf, udf);
    modport slave (input soft_clr, stall, jump_en, call_en, ret_en, jump_addr,
                   output pc, sp, ovf, udf);
endinterface

// File: rtl/inc16.sv
// inc16: combinational 16-bit incrementer, wraps FFFF to 0000
module inc16 (
    input  logic [15:0] a,
    output logic [15:0] y
);
    assign y = a + 16'd1;
endmodule

// File: rtl/ret_stack.sv
// ret_stack: DEPTH-entry LIFO of return addresses; only sp is reset
module ret_stack #(
    parameter int DEPTH = 8,
    parameter int W     = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           dout,
    output logic [$clog2(DEPTH):0] sp,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_idx;
    // sp == DEPTH aliases index 0, so sp-1 in AW bits still names the top entry
    assign rd_idx = sp[AW-1:0] - 1'b1;
    assign dout   = mem[rd_idx];
    assign full   = sp == (AW+1)'(DEPTH);
    assign empty  = sp == '0;

    // storage write; a push into a full stack is discarded
    always_ff @(posedge clk) begin
        if (push && !full && !clr) mem[sp[AW-1:0]] <= din;
    end

    // occupancy counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sp <= '0;
        else sp <= clr ? '0 : (push && !full) ? sp + 1'b1 : (pop && !empty) ? sp - 1'b1 : sp;
    end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: priority next-PC select with return stack and sticky error flags
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int              DEPTH     = 8,
    parameter logic [PC_W-1:0] RESET_VEC = pc_seq_pkg::RESET_VEC
) (
    input logic              clk,
    input logic              rst_n,
    pc_sequencer_if.slave    bus
);
    sel_t            sel;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] pc_next;
    logic [PC_W-1:0] top;
    logic            full;
    logic            empty;
    logic            live;

    // one incrementer feeds both the increment path and the call return address
    inc16 u_inc (.a(bus.pc), .y(pc_inc));

    ret_stack #(.DEPTH(DEPTH), .W(PC_W)) u_stack (
        .clk(clk), .rst_n(rst_n), .clr(sel == SEL_CLR),
        .push(sel == SEL_CALL), .pop(sel == SEL_RET),
        .din(pc_inc), .dout(top), .sp(bus.sp), .full(full), .empty(empty)
    );

    assign live = !bus.soft_clr && !bus.stall;

    // priority decode; a call on a full stack or a ret on an empty one degrades to increment
    always_comb begin
        sel = bus.soft_clr ? SEL_CLR :
              bus.stall    ? SEL_HOLD :
              bus.ret_en   ? (empty ? SEL_INC : SEL_RET) :
              bus.call_en  ? (full ? SEL_INC : SEL_CALL) :
              bus.jump_en  ? SEL_JUMP : SEL_INC;
        pc_next = sel == SEL_CLR                      ? RESET_VEC :
                  sel == SEL_INC                      ? pc_inc :
                  sel == SEL_JUMP || sel == SEL_CALL  ? bus.jump_addr :
                  sel == SEL_RET                      ? top : bus.pc;
    end

    // pc register and sticky flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.pc  <= RESET_VEC;
            bus.ovf <= 1'b0;
            bus.udf <= 1'b0;
        end else begin
            bus.pc  <= pc_next;
            bus.ovf <= bus.soft_clr ? 1'b0 : bus.ovf | (live && !bus.ret_en && bus.call_en && full);
            bus.udf <= bus.soft_clr ? 1'b0 : bus.udf | (live && bus.ret_en && empty);
        end
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed and random checks against a queue-based PC model
module tb_pc_sequencer;
    localparam int DEPTH = 8;
    localparam int SPW = $clog2(DEPTH) + 1;

    logic clk = 0;
    logic rst_n = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    pc_sequencer_if #(.DEPTH(DEPTH)) bus ();
    pc_sequencer #(.DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    // reference model: plain PC value, a queue as the return stack, two flags
    logic [15:0] m_pc = 16'h0000;
    logic [15:0] m_stk [$];
    logic        m_ovf = 0;
    logic        m_udf = 0;

    function automatic logic [15+SPW+2:0] exp_state();
        return {m_pc, SPW'(m_stk.size()), m_ovf, m_udf};
    endfunction

    function automatic logic [15+SPW+2:0] dut_state();
        return {bus.pc, bus.sp, bus.ovf, bus.udf};
    endfunction

    task automatic model_reset();
        m_pc = 16'h0000;
        m_stk.delete();
        m_ovf = 0;
        m_udf = 0;
    endtask

    // apply one cycle of requests to DUT and model; returns 1ns after the edge
    task automatic cyc(input logic clr, input logic st, input logic j, input logic c,
                       input logic r, input logic [15:0] a);
        bus.soft_clr = clr; bus.stall = st; bus.jump_en = j;
        bus.call_en = c; bus.ret_en = r; bus.jump_addr = a;
        @(posedge clk);
        if (clr) model_reset();
        else if (st) begin end
        else if (r) begin
            if (m_stk.size() == 0) begin m_udf = 1; m_pc = m_pc + 16'd1; end
            else m_pc = m_stk.pop_back();
        end else if (c) begin
            if (m_stk.size() == DEPTH) begin m_ovf = 1; m_pc = m_pc + 16'd1; end
            else begin m_stk.push_back(m_pc + 16'd1); m_pc = a; end
        end else if (j) m_pc = a;
        else m_pc = m_pc + 16'd1;
        #1;
    endtask

    task automatic test_reset();
        bus.soft_clr = 0; bus.stall = 0; bus.jump_en = 0;
        bus.call_en = 0; bus.ret_en = 0; bus.jump_addr = 16'h0;
        rst_n = 0;
        #12;
        n_cmp++;
        if (dut_state() !== exp_state()) begin
            n_bad++; $display("FAIL reset_state: got %h want %h", dut_state(), exp_state());
        end
        rst_n = 1;
        for (int i = 1; i <= 3; i++) begin
            cyc(0, 0, 0, 0, 0, 16'h0);
            n_cmp++;
            if (bus.pc !== 16'(i) || dut_state() !== exp_state()) begin
                n_bad++; $display("FAIL free_run_%0d: got %h want pc %h state %h", i, dut_state(), 16'(i), exp_state());
            end
        end
    endtask

    task automatic test_wrap();
        logic [15:0] want [2];
        want[0] = 16'hFFFF; want[1] = 16'h0000;
        cyc(0, 0, 1, 0, 0, 16'hFFFE);
        for (int i = 0; i < 2; i++) begin
            cyc(0, 0, 0, 0, 0, 16'h0);
            n_cmp++;
            if (bus.pc !== want[i] || bus.ovf !== 1'b0 || bus.udf !== 1'b0 || dut_state() !== exp_state()) begin
                n_bad++; $display("FAIL wrap_%0d: got %h want pc %h state %h", i, dut_state(), want[i], exp_state());
            end
        end
    endtask

    task automatic test_call_ret();
        cyc(0, 0, 1, 0, 0, 16'h0010);
        cyc(0, 0, 0, 1, 0, 16'h0200);
        n_cmp++;
        if (bus.pc !== 16'h0200 || bus.sp !== SPW'(1) || dut_state() !== exp_state()) begin
            n_bad++; $display("FAIL call: got pc %h sp %0d want pc 0200 sp 1", bus.pc, bus.sp);
        end
        cyc(0, 0, 0, 0, 1, 16'h0);
        n_cmp++;
        if (bus.pc !== 16'h0011 || bus.sp !== SPW'(0) || dut_state() !== exp_state()) begin
            n_bad++; $display("FAIL ret: got pc %h sp %0d want pc 0011 sp 0", bus.pc, bus.sp);
        end
    endtask

    task automatic test_overflow_underflow();
        for (int i = 0; i < DEPTH; i++) cyc(0, 0, 0, 1, 0, 16'h1000 + 16'(i * 16));
        cyc(0, 0, 0, 1, 0, 16'h7777);
        n_cmp++;
        if (bus.sp !== SPW'(DEPTH) || bus.ovf !== 1'b1 || bus.pc !== 16'h1000 + 16'((DEPTH - 1) * 16) + 16'd1
            || dut_state() !== exp_state()) begin
            n_bad++; $display("FAIL overflow: got %h want %h", dut_state(), exp_state());
        end
        for (int i = 0; i < DEPTH; i++) begin
            cyc(0, 0, 0, 0, 1, 16'h0);
            n_cmp++;
            if (dut_state() !== exp_state()) begin
                n_bad++; $display("FAIL unwind_%0d: got %h want %h", i, dut_state(), exp_state());
            end
        end
        cyc(0, 0, 0, 0, 1, 16'h0);
        n_cmp++;
        if (bus.udf !== 1'b1 || bus.sp !== SPW'(0) || dut_state() !== exp_state()) begin
            n_bad++; $display("FAIL underflow: got %h want %h", dut_state(), exp_state());
        end
    endtask

    task automatic test_stall_priority();
        logic [15:0] pc0;
        logic [SPW-1:0] sp0;
        cyc(1, 0, 0, 0, 0, 16'h0);
        cyc(0, 0, 0, 1, 0, 16'h0100);
        cyc(0, 0, 0, 1, 0, 16'h0300);
        pc0 = bus.pc; sp0 = bus.sp;
        for (int i = 0; i < 2; i++) begin
            cyc(0, 1, 1, 1, 1, 16'hABCD);
            n_cmp++;
            if (bus.pc !== pc0 || bus.sp !== sp0 || dut_state() !== exp_state()) begin
                n_bad++; $display("FAIL stall_%0d: got %h want %h", i, dut_state(), exp_state());
            end
        end
        cyc(0, 0, 0, 1, 1, 16'hABCD);
        n_cmp++;
        if (bus.sp !== SPW'(1) || bus.pc !== 16'h0101 || bus.ovf !== 1'b0 || dut_state() !== exp_state()) begin
            n_bad++; $display("FAIL call_ret_together: got %h want %h", dut_state(), exp_state());
        end
        cyc(0, 0, 1, 1, 0, 16'h0456);
        n_cmp++;
        if (bus.sp !== SPW'(2) || bus.pc !== 16'h0456 || dut_state() !== exp_state()) begin
            n_bad++; $display("FAIL call_over_jump: got %h want %h", dut_state(), exp_state());
        end
    endtask

    task automatic build_sp3_ovf();
        cyc(1, 0, 0, 0, 0, 16'h0);
        for (int i = 0; i <= DEPTH; i++) cyc(0, 0, 0, 1, 0, 16'h2000 + 16'(i));
        for (int i = 0; i < DEPTH - 3; i++) cyc(0, 0, 0, 0, 1, 16'h0);
        bus.call_en = 0; bus.ret_en = 0;
    endtask

    task automatic test_async_and_soft_clr();
        build_sp3_ovf();
        n_cmp++;
        if (bus.sp !== SPW'(3) || bus.ovf !== 1'b1) begin
            n_bad++; $display("FAIL pre_reset_state: got sp %0d ovf %b want sp 3 ovf 1", bus.sp, bus.ovf);
        end
        bus.ret_en = 1;
        #3 rst_n = 0;
        #1;
        model_reset();
        n_cmp++;
        if (dut_state() !== exp_state()) begin
            n_bad++; $display("FAIL async_reset: got %h want %h", dut_state(), exp_state());
        end
        rst_n = 1;
        build_sp3_ovf();
        cyc(1, 1, 1, 1, 1, 16'h5555);
        n_cmp++;
        if (bus.pc !== 16'h0000 || bus.sp !== SPW'(0) || bus.ovf !== 1'b0 || dut_state() !== exp_state()) begin
            n_bad++; $display("FAIL soft_clr: got %h want %h", dut_state(), exp_state());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(39) == 0, $urandom_range(7) == 0, $urandom_range(3) == 0,
                $urandom_range(2) == 0, $urandom_range(2) == 0, 16'($urandom));
            n_cmp++;
            if (dut_state() !== exp_state()) begin
                n_bad++; $display("FAIL random_%0d: got %h want %h", i, dut_state(), exp_state());
            end
        end
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_call_ret();
        test_overflow_underflow();
        test_stall_priority();
        test_async_and_soft_clr();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
